// File: rtl/csr_pkg.sv
// Shared CSR addresses, op/state encodings, mstatus bit positions and trap cause codes
// for the CSR trap controller and its write-data datapath.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int CAUSE_ILLEGAL_INSN = 2;
    localparam int CAUSE_ECALL_M      = 11;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RW,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_STATUS,
        ST_T_VEC,
        ST_R_STATUS,
        ST_R_EPC,
        ST_DONE
    } state_e;

    typedef enum logic [2:0] {
        WSEL_RW,
        WSEL_RS,
        WSEL_RC,
        WSEL_TRAP,
        WSEL_RET
    } wsel_e;

    typedef enum logic [1:0] {
        WSRC_CALC,
        WSRC_PC,
        WSRC_CAUSE
    } wsrc_e;

    function automatic logic is_known_csr(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/csr_wdata_calc.sv
// Write-data datapath: CSRRW/CSRRS/CSRRC results and mstatus updates for trap entry / MRET.
// Purely combinational, zero latency; no handshake.
module csr_wdata_calc
    import csr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wsel_e              sel,
    input  logic [WIDTH-1:0]   old_val,
    input  logic [WIDTH-1:0]   rs1,
    output logic [WIDTH-1:0]   wdata
);

    always_comb begin
        wdata = old_val;
        case (sel)
            WSEL_RW: wdata = rs1;
            WSEL_RS: wdata = old_val | rs1;
            WSEL_RC: wdata = old_val & ~rs1;
            WSEL_TRAP: begin
                wdata[MSTATUS_MPIE]                  = old_val[MSTATUS_MIE];
                wdata[MSTATUS_MIE]                   = 1'b0;
                wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            WSEL_RET: begin
                wdata[MSTATUS_MIE]                   = old_val[MSTATUS_MPIE];
                wdata[MSTATUS_MPIE]                  = 1'b1;
                wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            default: wdata = old_val;
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// CSR port initiator: CSRRW/S/C, ECALL trap entry and MRET sequenced over the single write port.
// Latency accept->resp: 2 (CSRR*), 5 (ECALL), 3 (MRET), 6 (illegal trap under CSR_TRAP_ILLEGAL_EN).
// Ready only in IDLE; response is a one-cycle pulse with no back-pressure.
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CAUSE_ECALL = CAUSE_ECALL_M
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [11:0]       req_csr_addr_i,
    input  logic [WIDTH-1:0]  req_rs1_i,
    input  logic              req_rs1_zero_i,
    input  logic [WIDTH-1:0]  req_pc_i,
    output logic [WIDTH-1:0]  csr_raddr_o,
    input  logic [WIDTH-1:0]  csr_rdata_i,
    output logic              csr_wen_o,
    output logic [WIDTH-1:0]  csr_waddr_o,
    output logic [WIDTH-1:0]  csr_wdata_o,
    output logic              resp_valid_o,
    output logic [WIDTH-1:0]  resp_rd_data_o,
    output logic              redirect_valid_o,
    output logic [WIDTH-1:0]  redirect_pc_o
);

    state_e            state, state_nxt;
    op_e               op_q;
    logic [11:0]       addr_q;
    logic [WIDTH-1:0]  rs1_q, pc_q, old_q, target_q;
    logic              rs1_zero_q, redir_q, illegal_q;

    logic              accept, known, trap_illegal;
    logic [11:0]       raddr_c, waddr_c;
    logic              wen_c;
    wsel_e             wsel;
    wsrc_e             wsrc;
    logic [WIDTH-1:0]  calc_wdata, wdata_c, cause_val;

    assign accept = req_valid_i & req_ready_o;
    assign known  = is_known_csr(addr_q);

`ifdef CSR_TRAP_ILLEGAL_EN
    assign trap_illegal = (state == ST_RW) && !known;
`else
    assign trap_illegal = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            op_q       <= OP_CSRRW;
            addr_q     <= '0;
            rs1_q      <= '0;
            rs1_zero_q <= 1'b0;
            pc_q       <= '0;
            old_q      <= '0;
            target_q   <= '0;
            redir_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op_e'(req_op_i);
                addr_q     <= req_csr_addr_i;
                rs1_q      <= req_rs1_i;
                rs1_zero_q <= req_rs1_zero_i;
                pc_q       <= req_pc_i;
                old_q      <= '0;
                target_q   <= '0;
                redir_q    <= 1'b0;
                illegal_q  <= 1'b0;
            end
            case (state)
                ST_RW: begin
                    if (known)        old_q     <= csr_rdata_i;
                    if (trap_illegal) illegal_q <= 1'b1;
                end
                ST_T_VEC: begin
                    target_q <= {csr_rdata_i[WIDTH-1:2], 2'b00};
                    redir_q  <= 1'b1;
                end
                ST_R_EPC: begin
                    target_q <= csr_rdata_i;
                    redir_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    case (op_e'(req_op_i))
                        OP_CSRRW, OP_CSRRS, OP_CSRRC: state_nxt = ST_RW;
                        OP_ECALL:                     state_nxt = ST_T_EPC;
                        OP_MRET:                      state_nxt = ST_R_STATUS;
                        default:                      state_nxt = ST_DONE;
                    endcase
                end
            end
            ST_RW:       state_nxt = trap_illegal ? ST_T_EPC : ST_DONE;
            ST_T_EPC:    state_nxt = ST_T_CAUSE;
            ST_T_CAUSE:  state_nxt = ST_T_STATUS;
            ST_T_STATUS: state_nxt = ST_T_VEC;
            ST_T_VEC:    state_nxt = ST_DONE;
            ST_R_STATUS: state_nxt = ST_R_EPC;
            ST_R_EPC:    state_nxt = ST_DONE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = (state == ST_IDLE);
        resp_valid_o = (state == ST_DONE) && rst_n_i;
        raddr_c      = '0;
        wen_c        = 1'b0;
        waddr_c      = '0;
        wsel         = WSEL_RW;
        wsrc         = WSRC_CALC;
        case (state)
            ST_RW: begin
                raddr_c = addr_q;
                case (op_q)
                    OP_CSRRS: wsel = WSEL_RS;
                    OP_CSRRC: wsel = WSEL_RC;
                    default:  wsel = WSEL_RW;
                endcase
                // Unknown addresses must never be written: the file aliases them onto mtvec.
                wen_c   = known && ((op_q == OP_CSRRW) || !rs1_zero_q);
                waddr_c = addr_q;
            end
            ST_T_EPC: begin
                wen_c   = 1'b1;
                waddr_c = CSR_MEPC;
                wsrc    = WSRC_PC;
            end
            ST_T_CAUSE: begin
                wen_c   = 1'b1;
                waddr_c = CSR_MCAUSE;
                wsrc    = WSRC_CAUSE;
            end
            ST_T_STATUS: begin
                raddr_c = CSR_MSTATUS;
                wsel    = WSEL_TRAP;
                wen_c   = 1'b1;
                waddr_c = CSR_MSTATUS;
            end
            ST_T_VEC:    raddr_c = CSR_MTVEC;
            ST_R_STATUS: begin
                raddr_c = CSR_MSTATUS;
                wsel    = WSEL_RET;
                wen_c   = 1'b1;
                waddr_c = CSR_MSTATUS;
            end
            ST_R_EPC:    raddr_c = CSR_MEPC;
            default: ;
        endcase
    end

    csr_wdata_calc #(.WIDTH(WIDTH)) u_wdata_calc (
        .sel     (wsel),
        .old_val (csr_rdata_i),
        .rs1     (rs1_q),
        .wdata   (calc_wdata)
    );

    assign cause_val = illegal_q ? WIDTH'(CAUSE_ILLEGAL_INSN) : WIDTH'(CAUSE_ECALL);
    assign wdata_c   = (wsrc == WSRC_PC)    ? pc_q      :
                       (wsrc == WSRC_CAUSE) ? cause_val : calc_wdata;

    assign csr_raddr_o      = {{(WIDTH-12){1'b0}}, raddr_c};
    assign csr_wen_o        = wen_c & rst_n_i;
    assign csr_waddr_o      = csr_wen_o ? {{(WIDTH-12){1'b0}}, waddr_c} : '0;
    assign csr_wdata_o      = csr_wen_o ? wdata_c : '0;
    assign resp_rd_data_o   = old_q;
    assign redirect_valid_o = resp_valid_o & redir_q;
    assign redirect_pc_o    = target_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed vector table, mid-sequence reset, then random ops
// checked against a behavioural CSR-file model.
module tb_csr_trap_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_rs1_zero;
    logic [2:0]  req_op;
    logic [11:0] req_addr;
    logic [31:0] req_rs1, req_pc;
    logic [31:0] csr_raddr, csr_rdata, csr_waddr, csr_wdata;
    logic        csr_wen;
    logic        resp_valid, redirect_valid;
    logic [31:0] resp_rd, redirect_pc;

    csr_trap_ctrl #(.WIDTH(32), .CAUSE_ECALL(11)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_csr_addr_i   (req_addr),
        .req_rs1_i        (req_rs1),
        .req_rs1_zero_i   (req_rs1_zero),
        .req_pc_i         (req_pc),
        .csr_raddr_o      (csr_raddr),
        .csr_rdata_i      (csr_rdata),
        .csr_wen_o        (csr_wen),
        .csr_waddr_o      (csr_waddr),
        .csr_wdata_o      (csr_wdata),
        .resp_valid_o     (resp_valid),
        .resp_rd_data_o   (resp_rd),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc)
    );

    // Behavioural CSR file; unknown addresses read as a recognisable non-zero pattern.
    logic [31:0] f_ms = '0, f_tv = '0, f_ep = '0, f_mc = '0;
    logic        do_preset = 1'b0;
    logic [31:0] p_ms, p_tv, p_ep, p_mc;
    logic [11:0] obs_a [2048];
    logic [31:0] obs_d [2048];
    int          obs_n = 0;
    int          bad_writes = 0;

    always_comb begin
        case (csr_raddr)
            32'h300: csr_rdata = f_ms;
            32'h305: csr_rdata = f_tv;
            32'h341: csr_rdata = f_ep;
            32'h342: csr_rdata = f_mc;
            default: csr_rdata = 32'hDEAD_BEEF;
        endcase
    end

    always @(posedge clk) begin
        if (do_preset) begin
            f_ms <= p_ms; f_tv <= p_tv; f_ep <= p_ep; f_mc <= p_mc;
        end else if (csr_wen) begin
            case (csr_waddr)
                32'h300: f_ms <= csr_wdata;
                32'h305: f_tv <= csr_wdata;
                32'h341: f_ep <= csr_wdata;
                32'h342: f_mc <= csr_wdata;
                default: bad_writes <= bad_writes + 1;
            endcase
            if (!rst_n) bad_writes <= bad_writes + 1;
            obs_a[obs_n % 2048] <= csr_waddr[11:0];
            obs_d[obs_n % 2048] <= csr_wdata;
            obs_n <= obs_n + 1;
        end
    end

    typedef struct packed {
        logic [1:0]  nw;
        logic [11:0] wa0; logic [31:0] wd0;
        logic [11:0] wa1; logic [31:0] wd1;
        logic [11:0] wa2; logic [31:0] wd2;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic [3:0]  lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic        rz;
        logic [31:0] pc, ms, tv, ep;
        exp_t        e;
    } vec_t;

    int n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] nw,
                                    input logic [11:0] a0, input logic [31:0] d0,
                                    input logic [11:0] a1, input logic [31:0] d1,
                                    input logic [11:0] a2, input logic [31:0] d2,
                                    input logic [31:0] rd, input logic redir,
                                    input logic [31:0] rpc, input logic [3:0] lat);
        exp_t e;
        e.nw = nw; e.wa0 = a0; e.wd0 = d0; e.wa1 = a1; e.wd1 = d1; e.wa2 = a2; e.wd2 = d2;
        e.rd = rd; e.redir = redir; e.rpc = rpc; e.lat = lat;
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [2:0] op, input logic [11:0] addr,
                                    input logic [31:0] rs1, input logic rz, input logic [31:0] pc,
                                    input logic [31:0] ms, input logic [31:0] tv,
                                    input logic [31:0] ep, input exp_t e);
        vec_t v;
        v.op = op; v.addr = addr; v.rs1 = rs1; v.rz = rz; v.pc = pc;
        v.ms = ms; v.tv = tv; v.ep = ep; v.e = e;
        return v;
    endfunction

    function automatic bit tb_known(input logic [11:0] a);
        return a == 12'h300 || a == 12'h305 || a == 12'h341 || a == 12'h342;
    endfunction

    // Trap entry: MPIE takes MIE, MIE clears, MPP becomes 3.
    function automatic exp_t trap_exp(input logic [31:0] cause, input logic [31:0] pc,
                                      input logic [31:0] ms, input logic [31:0] tv);
        logic [31:0] nms;
        nms = (ms & ~32'h1888) | 32'h1800 | ((ms & 32'h8) << 4);
        return mk_exp(2'd3, 12'h341, pc, 12'h342, cause, 12'h300, nms,
                      32'h0, 1'b1, tv & ~32'h3, 4'd5);
    endfunction

    function automatic exp_t model(input logic [2:0] op, input logic [11:0] a,
                                   input logic [31:0] rs1, input logic rz, input logic [31:0] pc,
                                   input logic [31:0] ms, input logic [31:0] tv,
                                   input logic [31:0] ep, input logic [31:0] mc);
        exp_t e;
        logic [31:0] old, nv;
        e = '0;
        case (a)
            12'h300: old = ms;
            12'h305: old = tv;
            12'h341: old = ep;
            12'h342: old = mc;
            default: old = 32'h0;
        endcase
        if (op <= 3'd2) begin
            if (tb_known(a)) begin
                e.lat = 4'd2;
                e.rd  = old;
                if (op == 3'd0 || !rz) begin
                    nv = (op == 3'd0) ? rs1 : (op == 3'd1) ? (old | rs1) : (old & ~rs1);
                    e.nw = 2'd1; e.wa0 = a; e.wd0 = nv;
                end
            end else begin
`ifdef CSR_TRAP_ILLEGAL_EN
                e = trap_exp(32'd2, pc, ms, tv);
                e.lat = 4'd6;
`else
                e.lat = 4'd2;
`endif
            end
        end else if (op == 3'd3) begin
            e = trap_exp(32'd11, pc, ms, tv);
        end else begin
            e.nw = 2'd1; e.wa0 = 12'h300;
            e.wd0 = (ms & ~32'h1888) | 32'h1880 | ((ms & 32'h80) >> 4);
            e.redir = 1'b1; e.rpc = ep; e.lat = 4'd3;
        end
        return e;
    endfunction

    task automatic preset(input logic [31:0] ms, input logic [31:0] tv,
                          input logic [31:0] ep, input logic [31:0] mc);
        @(negedge clk);
        p_ms = ms; p_tv = tv; p_ep = ep; p_mc = mc;
        do_preset = 1'b1;
        @(negedge clk);
        do_preset = 1'b0;
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [11:0] a,
                       input logic [31:0] rs1, input logic rz, input logic [31:0] pc,
                       input exp_t e);
        int start, lat, nw;
        logic [31:0] rd_got, rpc_got, ga, gd, wa, wd;
        logic rv_got;
        rd_got = '0; rpc_got = '0; rv_got = 1'b0;
        @(negedge clk);
        chk({nm, " idle_ready"}, 32'(req_ready), 32'd1);
        chk({nm, " idle_resp"}, 32'(resp_valid), 32'd0);
        req_valid = 1'b1; req_op = op; req_addr = a; req_rs1 = rs1;
        req_rs1_zero = rz; req_pc = pc;
        start = obs_n;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k; rd_got = resp_rd; rv_got = redirect_valid; rpc_got = redirect_pc;
                req_valid = 1'b0;
            end else begin
                chk({nm, " busy_ready"}, 32'(req_ready), 32'd0);
                // Junk request while busy must be ignored.
                req_valid = 1'b1; req_op = 3'($urandom_range(0, 4)); req_addr = 12'($urandom);
                req_rs1 = $urandom; req_pc = $urandom; req_rs1_zero = 1'($urandom);
            end
        end
        req_valid = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(e.lat));
        chk({nm, " rd"}, rd_got, e.rd);
        chk({nm, " redirect_valid"}, 32'(rv_got), 32'(e.redir));
        if (e.redir) chk({nm, " redirect_pc"}, rpc_got, e.rpc);
        nw = obs_n - start;
        chk({nm, " nwrites"}, 32'(nw), 32'(e.nw));
        for (int i = 0; i < int'(e.nw); i++) begin
            if (i < nw) begin
                wa = (i == 0) ? 32'(e.wa0) : (i == 1) ? 32'(e.wa1) : 32'(e.wa2);
                wd = (i == 0) ? e.wd0 : (i == 1) ? e.wd1 : e.wd2;
                ga = 32'(obs_a[(start + i) % 2048]);
                gd = obs_d[(start + i) % 2048];
                chk($sformatf("%s w%0d_addr", nm, i), ga, wa);
                chk($sformatf("%s w%0d_data", nm, i), gd, wd);
            end
        end
    endtask

    task automatic random_tests(input int n);
        logic [31:0] ms, tv, ep, mc, rs1, pc;
        logic [2:0]  op;
        logic [11:0] a;
        logic        rz;
        exp_t        e;
        for (int t = 0; t < n; t++) begin
            ms = $urandom; tv = $urandom; ep = $urandom; mc = $urandom;
            rs1 = $urandom; pc = $urandom;
            op = 3'($urandom_range(0, 4));
            rz = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h341;
                3: a = 12'h342;
                default: begin
                    a = 12'($urandom);
                    while (tb_known(a)) a = 12'($urandom);
                end
            endcase
            preset(ms, tv, ep, mc);
            e = model(op, a, rs1, rz, pc, ms, tv, ep, mc);
            run($sformatf("rnd%0d", t), op, a, rs1, rz, pc, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        int start;
        bit saw_resp;

        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_rs1 = '0;
        req_rs1_zero = 1'b0; req_pc = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset wen", 32'(csr_wen), 32'd0);
        chk("reset raddr", csr_raddr, 32'd0);
        chk("reset rd", resp_rd, 32'd0);
        chk("reset redirect_pc", redirect_pc, 32'd0);
        chk("reset wdata", csr_wdata, 32'd0);
        rst_n = 1'b1;

        vecs.push_back(mk_vec(3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0,
            mk_exp(2'd1, 12'h305, 32'h8000_0100, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h0, 1'b0, 32'h0, 4'd2)));
        vecs.push_back(mk_vec(3'd1, 12'h300, 32'h8, 1'b0, 32'h0, 32'h1800, 32'h0, 32'h0,
            mk_exp(2'd1, 12'h300, 32'h1808, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h1800, 1'b0, 32'h0, 4'd2)));
        vecs.push_back(mk_vec(3'd2, 12'h300, 32'h8, 1'b1, 32'h0, 32'h1808, 32'h0, 32'h0,
            mk_exp(2'd0, 12'h0, 32'h0, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h1808, 1'b0, 32'h0, 4'd2)));
        vecs.push_back(mk_vec(3'd3, 12'h0, 32'h0, 1'b0, 32'h8000_0040, 32'h1808, 32'h8000_0200, 32'h0,
            mk_exp(2'd3, 12'h341, 32'h8000_0040, 12'h342, 32'd11, 12'h300, 32'h1880,
                   32'h0, 1'b1, 32'h8000_0200, 4'd5)));
        vecs.push_back(mk_vec(3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 32'h1880, 32'h0, 32'h8000_0044,
            mk_exp(2'd1, 12'h300, 32'h1888, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h0, 1'b1, 32'h8000_0044, 4'd3)));
`ifdef CSR_TRAP_ILLEGAL_EN
        vecs.push_back(mk_vec(3'd0, 12'h7C0, 32'h1234_5678, 1'b0, 32'h8000_0080, 32'h8, 32'h8000_0300, 32'h0,
            mk_exp(2'd3, 12'h341, 32'h8000_0080, 12'h342, 32'd2, 12'h300, 32'h1880,
                   32'h0, 1'b1, 32'h8000_0300, 4'd6)));
`else
        vecs.push_back(mk_vec(3'd0, 12'h7C0, 32'h1234_5678, 1'b0, 32'h8000_0080, 32'h8, 32'h8000_0300, 32'h0,
            mk_exp(2'd0, 12'h0, 32'h0, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h0, 1'b0, 32'h0, 4'd2)));
`endif
        vecs.push_back(mk_vec(3'd3, 12'h0, 32'h0, 1'b0, 32'h100, 32'h0, 32'h8000_0203, 32'h0,
            mk_exp(2'd3, 12'h341, 32'h100, 12'h342, 32'd11, 12'h300, 32'h1800,
                   32'h0, 1'b1, 32'h8000_0200, 4'd5)));
        vecs.push_back(mk_vec(3'd2, 12'h300, 32'h8, 1'b0, 32'h0, 32'h1888, 32'h0, 32'h0,
            mk_exp(2'd1, 12'h300, 32'h1880, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h1888, 1'b0, 32'h0, 4'd2)));
        vecs.push_back(mk_vec(3'd1, 12'h341, 32'hF0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h8000_0044,
            mk_exp(2'd0, 12'h0, 32'h0, 12'h0, 32'h0, 12'h0, 32'h0,
                   32'h8000_0044, 1'b0, 32'h0, 4'd2)));

        foreach (vecs[i]) begin
            preset(vecs[i].ms, vecs[i].tv, vecs[i].ep, 32'h0);
            run($sformatf("dir%0d", i), vecs[i].op, vecs[i].addr, vecs[i].rs1, vecs[i].rz,
                vecs[i].pc, vecs[i].e);
        end

        // Reset while the ECALL sequence sits in T_CAUSE: mcause write must be suppressed.
        preset(32'h1808, 32'h8000_0200, 32'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; req_pc = 32'h8000_0040;
        start = obs_n;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid wen", 32'(csr_wen), 32'd0);
        @(negedge clk);
        chk("rst_mid ready", 32'(req_ready), 32'd1);
        chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid redirect_valid", 32'(redirect_valid), 32'd0);
        rst_n = 1'b1;
        saw_resp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid || redirect_valid) saw_resp = 1'b1;
        end
        chk("rst_mid late_resp", 32'(saw_resp), 32'd0);
        chk("rst_mid nwrites", 32'(obs_n - start), 32'd1);

        random_tests(150);

        chk("illegal_or_reset_writes", 32'(bad_writes), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
